// File: rtl/mem_sweep_checker_pkg.sv
// Shared types and helpers for the memory sweep checker.
package mem_chk_pkg;

  localparam int unsigned CSUM_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_DRAIN,
    ST_DONE
  } state_t;

  // Number of CSUM_W-wide slices needed to cover a word of the given width.
  function automatic int unsigned fold_slices(input int unsigned wid);
    return (wid + CSUM_W - 1) / CSUM_W;
  endfunction

endpackage

// File: rtl/mem_sweep_checker_if.sv
// Read port between the sweep checker and the memory under test.
interface mem_sweep_checker_if #(
  parameter int unsigned WID_MEM = 4092
) ();
  logic [31:0]        raddr;
  logic [WID_MEM-1:0] rdata;

  modport master (output raddr, input rdata);
  modport slave  (input raddr, output rdata);
endinterface

// File: rtl/mem_sweep_checker_word_fold.sv
// XOR-folds one memory word into a 32-bit value; top slice zero-padded.
module word_fold
  import mem_chk_pkg::*;
#(
  parameter int unsigned WID_MEM = 4092
) (
  input  logic [WID_MEM-1:0] word,
  output logic [CSUM_W-1:0]  fold
);

  localparam int unsigned NSL = fold_slices(WID_MEM);

  logic [NSL*CSUM_W-1:0] padded;

  // Pad the word to whole slices, then XOR all slices together.
  always_comb begin
    padded = '0;
    padded[WID_MEM-1:0] = word;
    fold = '0;
    for (int unsigned i = 0; i < NSL; i++) begin
      fold = fold ^ padded[i*CSUM_W +: CSUM_W];
    end
  end

endmodule

// File: rtl/mem_sweep_checker.sv
// Sweeps DEPTH_MEM words of a 1-cycle-latency memory, accumulates a
// rotate/XOR checksum and compares it against a golden value.
module mem_sweep_checker
  import mem_chk_pkg::*;
#(
  parameter int unsigned WID_MEM   = 4092,
  parameter int unsigned DEPTH_MEM = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic [CSUM_W-1:0]    expected,
  mem_sweep_checker_if.master  mem,
  output logic                 busy,
  output logic                 done,
  output logic [CSUM_W-1:0]    checksum,
  output logic                 match
);

  state_t            state, state_nx;
  logic [31:0]       raddr_r;
  logic              rd_vld;
  logic [CSUM_W-1:0] csum_r;
  logic [CSUM_W-1:0] csum_nx;
  logic [CSUM_W-1:0] fold_w;
  logic              match_r;
  logic              last;

  word_fold #(.WID_MEM(WID_MEM)) u_fold (
    .word (mem.rdata),
    .fold (fold_w)
  );

  assign last    = (raddr_r == 32'(DEPTH_MEM - 1));
  assign csum_nx = {csum_r[CSUM_W-2:0], csum_r[CSUM_W-1]} ^ fold_w;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nx;
  end

  // Next-state logic; abort takes priority while a sweep is active.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE, ST_DONE: if (start) state_nx = ST_READ;
      ST_READ: begin
        if (abort)     state_nx = ST_IDLE;
        else if (last) state_nx = ST_DRAIN;
      end
      ST_DRAIN: state_nx = abort ? ST_IDLE : ST_DONE;
      default:  state_nx = ST_IDLE;
    endcase
  end

  // Address counter, read-valid pipe, checksum and match registers.
  // An aborting edge neither folds the in-flight word nor advances raddr.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      raddr_r <= '0;
      rd_vld  <= 1'b0;
      csum_r  <= '0;
      match_r <= 1'b0;
    end else begin
      rd_vld <= (state == ST_READ) && !abort;
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            raddr_r <= '0;
            csum_r  <= '0;
            match_r <= 1'b0;
          end
        end
        ST_READ: begin
          if (!abort) begin
            if (!last) raddr_r <= raddr_r + 32'd1;
            if (rd_vld) csum_r <= csum_nx;
          end
        end
        ST_DRAIN: begin
          if (!abort) begin
            if (rd_vld) csum_r <= csum_nx;
            match_r <= (csum_nx == expected);
          end
        end
        default: ;
      endcase
    end
  end

  assign mem.raddr = raddr_r;
  assign busy      = (state == ST_READ) || (state == ST_DRAIN);
  assign done      = (state == ST_DONE);
  assign checksum  = csum_r;
  assign match     = match_r;

endmodule

// File: tb/tb_mem_sweep_checker.sv
// Scoreboard bench: an 8-bit instance for sweep/abort/reset/restart cases
// and a 4092-bit instance for wide-word folding.
module tb_mem_sweep_checker;

  localparam int unsigned WA = 8;
  localparam int unsigned WB = 4092;
  localparam int unsigned D  = 4;

  typedef struct {
    logic [31:0] csum;
    logic        m;
    int          at_edge;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_a, abort_a, busy_a, done_a, match_a;
  logic [31:0] exp_a, csum_a;
  logic        start_b, abort_b, busy_b, done_b, match_b;
  logic [31:0] exp_b, csum_b;

  logic [WA-1:0] mema [D];
  logic [WB-1:0] memb [D];

  exp_t qa[$];
  exp_t qb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  logic dqa    = 1'b0;
  logic dqb    = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  mem_sweep_checker_if #(.WID_MEM(WA)) ifa ();
  mem_sweep_checker_if #(.WID_MEM(WB)) ifb ();

  mem_sweep_checker #(.WID_MEM(WA), .DEPTH_MEM(D)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .abort(abort_a),
    .expected(exp_a), .mem(ifa), .busy(busy_a), .done(done_a),
    .checksum(csum_a), .match(match_a)
  );

  mem_sweep_checker #(.WID_MEM(WB), .DEPTH_MEM(D)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .abort(abort_b),
    .expected(exp_b), .mem(ifb), .busy(busy_b), .done(done_b),
    .checksum(csum_b), .match(match_b)
  );

  // Registered-read memory models.
  always @(posedge clk) ifa.rdata <= mema[ifa.raddr[1:0]];
  always @(posedge clk) ifb.rdata <= memb[ifb.raddr[1:0]];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, want %h (edge %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor A: compares on each rising edge of done, and guards raddr range.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      chk("a_raddr_range", 32'(ifa.raddr < D), 32'd1);
      if (done_a && !dqa) begin
        if (qa.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL a_unexpected_done: got done=1, want 0 (edge %0d)", cyc);
        end else begin
          e = qa.pop_front();
          chk("a_checksum", csum_a, e.csum);
          chk("a_match", 32'(match_a), 32'(e.m));
          chk("a_done_edge", 32'(cyc), 32'(e.at_edge));
        end
      end
      dqa = done_a;
    end
  end

  // Monitor B.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (done_b && !dqb) begin
        if (qb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL b_unexpected_done: got done=1, want 0 (edge %0d)", cyc);
        end else begin
          e = qb.pop_front();
          chk("b_checksum", csum_b, e.csum);
          chk("b_match", 32'(match_b), 32'(e.m));
          chk("b_done_edge", 32'(cyc), 32'(e.at_edge));
        end
      end
      dqb = done_b;
    end
  end

  task automatic drain_a();
    for (int i = 0; i < 30; i++) begin
      if (qa.size() == 0) break;
      @(negedge clk);
    end
    if (qa.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL a_timeout: got %0d pending, want 0", qa.size());
      qa.delete();
    end
  endtask

  task automatic drain_b();
    for (int i = 0; i < 30; i++) begin
      if (qb.size() == 0) break;
      @(negedge clk);
    end
    if (qb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL b_timeout: got %0d pending, want 0", qb.size());
      qb.delete();
    end
  endtask

  task automatic sweep_a(input logic [31:0] ex, input logic [31:0] csum_exp, input logic m_exp);
    @(negedge clk);
    start_a = 1'b1;
    exp_a   = ex;
    @(posedge clk); #1;
    start_a = 1'b0;
    qa.push_back('{csum_exp, m_exp, cyc + 5});
    chk("a_raddr_seq", ifa.raddr, 32'd0);
    chk("a_busy", 32'(busy_a), 32'd1);
    chk("a_csum_clear", csum_a, 32'd0);
    for (int k = 1; k < 4; k++) begin
      @(posedge clk); #1;
      chk("a_raddr_seq", ifa.raddr, 32'(k));
    end
    drain_a();
  endtask

  initial begin
    int s;
    reset   = 1'b1;
    start_a = 1'b0; abort_a = 1'b0; exp_a = '0;
    start_b = 1'b0; abort_b = 1'b0; exp_b = '0;
    mema[0] = 8'h01; mema[1] = 8'h02; mema[2] = 8'h03; mema[3] = 8'h04;
    for (int i = 0; i < 4; i++) memb[i] = '0;
    memb[2][WB-1] = 1'b1;

    #12;
    chk("rst_raddr", ifa.raddr, 32'd0);
    chk("rst_csum", csum_a, 32'd0);
    chk("rst_busy", 32'(busy_a), 32'd0);
    chk("rst_done", 32'(done_a), 32'd0);
    chk("rst_match", 32'(match_a), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_no_start", 32'(busy_a), 32'd0);

    // Basic sweep: 1,2,3,4 -> 0x00000002, then a mismatching golden value.
    sweep_a(32'h2, 32'h2, 1'b1);
    sweep_a(32'h3, 32'h2, 1'b0);

    // Abort in the cycle raddr=2: partial checksum (word 0 only) held.
    @(negedge clk);
    start_a = 1'b1; exp_a = 32'h2;
    @(posedge clk); #1;
    start_a = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("ab_raddr_pre", ifa.raddr, 32'd2);
    @(negedge clk);
    abort_a = 1'b1;
    @(posedge clk); #1;
    abort_a = 1'b0;
    chk("ab_busy", 32'(busy_a), 32'd0);
    chk("ab_done", 32'(done_a), 32'd0);
    chk("ab_raddr", ifa.raddr, 32'd2);
    chk("ab_csum", csum_a, 32'd1);
    repeat (8) @(negedge clk);
    chk("ab_done_later", 32'(done_a), 32'd0);
    sweep_a(32'h2, 32'h2, 1'b1);

    // Asynchronous reset between edges, mid-READ.
    @(negedge clk);
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    chk("ar_raddr", ifa.raddr, 32'd0);
    chk("ar_csum", csum_a, 32'd0);
    chk("ar_busy", 32'(busy_a), 32'd0);
    chk("ar_done", 32'(done_a), 32'd0);
    chk("ar_match", 32'(match_a), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    chk("ar_no_done", 32'(done_a), 32'd0);
    chk("ar_idle", 32'(busy_a), 32'd0);

    // Start held high: one sweep, then a restart out of DONE.
    @(negedge clk);
    start_a = 1'b1; exp_a = 32'h2;
    @(posedge clk); #1;
    s = cyc;
    qa.push_back('{32'h2, 1'b1, s + 5});
    qa.push_back('{32'h2, 1'b1, s + 11});
    repeat (5) @(posedge clk);
    #1;
    chk("hold_done", 32'(done_a), 32'd1);
    @(posedge clk); #1;
    chk("hold_restart_done", 32'(done_a), 32'd0);
    chk("hold_restart_csum", csum_a, 32'd0);
    chk("hold_restart_busy", 32'(busy_a), 32'd1);
    start_a = 1'b0;
    drain_a();

    // Wide word: only bit 4091 of word 2 set.
    @(negedge clk);
    start_b = 1'b1; exp_b = 32'h1000_0000;
    @(posedge clk); #1;
    start_b = 1'b0;
    qb.push_back('{32'h1000_0000, 1'b1, cyc + 5});
    drain_b();

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mem_sweep_checker.md
MEM_SWEEP_CHECKER -- requirements
Module: mem_sweep_checker

Interface
REQ-001 SHALL have parameter WID_MEM, default 4092, meaning the memory word width in bits and matching the memory under test.
REQ-002 SHALL have parameter DEPTH_MEM, default 4, meaning the number of words swept.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit, asynchronous active-high reset.
REQ-005 SHALL have port start, input, 1 bit, requesting a sweep; sampled only in IDLE or DONE.
REQ-006 SHALL have port abort, input, 1 bit, which cancels a sweep in progress.
REQ-007 SHALL have port expected, input, 32 bits, the golden checksum.
REQ-008 SHALL have port raddr, output, 32 bits, the registered read address driven to the memory.
REQ-009 SHALL have port rdata, input, WID_MEM bits, the memory dout with 1-cycle registered read latency.
REQ-010 SHALL have port busy, output, 1 bit, high in READ and DRAIN.
REQ-011 SHALL have port done, output, 1 bit, held high in DONE.
REQ-012 SHALL have port checksum, output, 32 bits, the running and final checksum.
REQ-013 SHALL have port match, output, 1 bit, giving checksum==expected, valid while done.

Function
REQ-014 SHALL implement states IDLE, READ, DRAIN and DONE.
REQ-015 SHALL leave IDLE or DONE for READ when start=1, clearing checksum to 0, raddr to 0 and match to 0.
REQ-016 SHALL, in READ, increment raddr each cycle, and move to DRAIN on the cycle raddr=DEPTH_MEM-1 (no increment past it).
REQ-017 SHALL, in DRAIN, stay one cycle and then enter DONE.
REQ-018 SHALL register a valid flag one cycle behind each issued address; rdata for an address presented in cycle t SHALL be folded at the edge ending cycle t+1.
REQ-019 SHALL fold each word as: XOR of consecutive 32-bit slices of rdata, with the top slice zero-padded when WID_MEM is not a multiple of 32.
REQ-020 SHALL update the checksum as: checksum <= rotate-left-by-1(checksum) XOR fold(rdata).
REQ-021 SHALL raise done at the (DEPTH_MEM+1)th rising edge after the edge that sampled start, with match registered at that same edge.
REQ-022 SHALL ignore start while busy=1.
REQ-023 SHALL, on abort=1 in READ or DRAIN, return to IDLE next edge; done stays 0, checksum holds its partial value, and the in-flight fold is discarded.
REQ-024 SHALL let abort win over start when both are asserted in the same cycle.
REQ-025 SHALL have no effect from abort in IDLE or DONE.
REQ-026 SHALL never drive a raddr value at or above DEPTH_MEM.
REQ-027 SHALL behave correctly for DEPTH_MEM=1: READ lasts one cycle and done rises at the 2nd edge.

Reset
REQ-028 SHALL, on reset=1, immediately force state IDLE, raddr=0, checksum=0, busy=0, done=0, match=0 and the valid flag to 0, regardless of clk.
REQ-029 SHALL abandon a sweep when reset occurs mid-sweep, with no done pulse after release.
REQ-030 SHALL, on reset release, do nothing until start is sampled.

Structure
REQ-031 SHALL take the state enum, CSUM_W=32 and a fold-width helper from a shared package mem_chk_pkg.
REQ-032 SHALL place the combinational XOR fold in sub-module word_fold, parameterised by WID_MEM and producing 32 bits.
REQ-033 SHALL connect raddr and rdata directly to the memory's raddr and dout, with no extra pipeline.

Verification
REQ-034 SHALL cover the sweep: WID_MEM=8, DEPTH_MEM=4, memory 01,02,03,04, start pulse -> raddr 0,1,2,3, done at the 5th edge, checksum=0x00000002, match=1 with expected=0x00000002.
REQ-035 SHALL cover a mismatch: same contents, expected=0x00000003 -> done=1, match=0, checksum=0x00000002.
REQ-036 SHALL cover a wide word: WID_MEM=4092, DEPTH_MEM=4, all words 0 except word 2 with bit 4091 set -> fold of word 2 = 0x08000000, final checksum=0x10000000.
REQ-037 SHALL cover abort: abort in the cycle raddr=2 -> IDLE next edge, done never rises, raddr never reaches 3; a subsequent start gives the full correct result.
REQ-038 SHALL cover async reset: reset asserted mid-READ between clock edges -> outputs zero immediately, no done after release.
REQ-039 SHALL cover start while busy: start held high throughout a sweep -> single sweep, done at the 5th edge; start still high in DONE restarts the sweep, clearing checksum.
